// File: rtl/enemy_bullet_collide_pkg.sv
// Shared game definitions: slot count, packed {x,y} screen position, box sizes,
// life count and the controller state encodings.
package enemy_bullet_collide_pkg;

  localparam int unsigned DEF_NUM_SLOTS    = 8;
  localparam int unsigned DEF_BULLET_W     = 6;
  localparam int unsigned DEF_BULLET_H     = 20;
  localparam int unsigned DEF_PLAYER_W     = 36;
  localparam int unsigned DEF_PLAYER_H     = 36;
  localparam int unsigned DEF_START_LIVES  = 3;
  localparam int unsigned DEF_INVULN_TICKS = 60;

  localparam int unsigned POS_X_W = 10;
  localparam int unsigned POS_Y_W = 9;
  localparam int unsigned POS_W   = POS_X_W + POS_Y_W;

  typedef struct packed {
    logic [POS_X_W-1:0] x;
    logic [POS_Y_W-1:0] y;
  } pos_t;

  // Parked (retired) bullets sit at the all-ones coordinate.
  localparam pos_t DEAD_POSITION = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  function automatic pos_t make_pos(input logic [POS_X_W-1:0] x,
                                    input logic [POS_Y_W-1:0] y);
    pos_t p;
    p.x = x;
    p.y = y;
    return p;
  endfunction

endpackage

// File: rtl/enemy_bullet_collide_if.sv
// Frame tick, bullet/player positions in; kill/hit pulses and life status out.
interface enemy_bullet_collide_if
  import enemy_bullet_collide_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS
);

  logic                       i_Tick;
  logic [NUM_SLOTS-1:0]       i_BulletValid;
  logic [POS_W*NUM_SLOTS-1:0] i_BulletPos;
  logic [POS_W-1:0]           i_PlayerPos;
  logic [NUM_SLOTS-1:0]       o_BulletKill;
  logic                       o_PlayerHit;
  logic [1:0]                 o_Lives;
  logic                       o_GameOver;
  logic                       o_Busy;

  modport slave (
    input  i_Tick, i_BulletValid, i_BulletPos, i_PlayerPos,
    output o_BulletKill, o_PlayerHit, o_Lives, o_GameOver, o_Busy
  );

  modport master (
    output i_Tick, i_BulletValid, i_BulletPos, i_PlayerPos,
    input  o_BulletKill, o_PlayerHit, o_Lives, o_GameOver, o_Busy
  );

endinterface

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap between a live box A and box B; touching
// edges do not count and parked A boxes never hit.
module aabb_overlap
  import enemy_bullet_collide_pkg::*;
#(
  parameter int unsigned A_W = DEF_BULLET_W,
  parameter int unsigned A_H = DEF_BULLET_H,
  parameter int unsigned B_W = DEF_PLAYER_W,
  parameter int unsigned B_H = DEF_PLAYER_H
) (
  input  logic a_valid,
  input  pos_t a_pos,
  input  pos_t b_pos,
  output logic hit
);

  // One extra bit so boxes near the right/bottom screen edge never wrap.
  localparam logic [POS_X_W:0] A_W_EXT = (POS_X_W+1)'(A_W);
  localparam logic [POS_Y_W:0] A_H_EXT = (POS_Y_W+1)'(A_H);
  localparam logic [POS_X_W:0] B_W_EXT = (POS_X_W+1)'(B_W);
  localparam logic [POS_Y_W:0] B_H_EXT = (POS_Y_W+1)'(B_H);

  logic [POS_X_W:0] ax, bx, a_right, b_right;
  logic [POS_Y_W:0] ay, by, a_bottom, b_bottom;
  logic             x_overlap, y_overlap;

  always_comb begin
    ax        = {1'b0, a_pos.x};
    bx        = {1'b0, b_pos.x};
    ay        = {1'b0, a_pos.y};
    by        = {1'b0, b_pos.y};
    a_right   = ax + A_W_EXT;
    b_right   = bx + B_W_EXT;
    a_bottom  = ay + A_H_EXT;
    b_bottom  = by + B_H_EXT;
    x_overlap = (ax < b_right) && (bx < a_right);
    y_overlap = (ay < b_bottom) && (by < a_bottom);
    hit       = a_valid && (a_pos != DEAD_POSITION) && x_overlap && y_overlap;
  end

endmodule

// File: rtl/enemy_bullet_collide.sv
// Per-frame enemy bullet vs player collision: snapshot on tick, test one slot
// per cycle, then report kill pulses and charge at most one life per frame.
module enemy_bullet_collide
  import enemy_bullet_collide_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int unsigned BULLET_W     = DEF_BULLET_W,
  parameter int unsigned BULLET_H     = DEF_BULLET_H,
  parameter int unsigned PLAYER_W     = DEF_PLAYER_W,
  parameter int unsigned PLAYER_H     = DEF_PLAYER_H,
  parameter int unsigned START_LIVES  = DEF_START_LIVES,
  parameter int unsigned INVULN_TICKS = DEF_INVULN_TICKS
) (
  input logic                   i_Clk,
  input logic                   i_Rst,
  enemy_bullet_collide_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned INV_W = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            slot_q, slot_d;
  logic [NUM_SLOTS-1:0]        valid_snap_q, valid_snap_d;
  pos_t [NUM_SLOTS-1:0]        pos_snap_q, pos_snap_d;
  pos_t                        player_snap_q, player_snap_d;
  logic [NUM_SLOTS-1:0]        hit_mask_q, hit_mask_d;
  logic [INV_W-1:0]            invuln_q, invuln_d;
  logic [1:0]                  lives_q, lives_d;
  logic [NUM_SLOTS-1:0]        bullet_kill_q, bullet_kill_d;
  logic                        player_hit_q, player_hit_d;
  logic                        game_over_q, game_over_d;
  logic                        busy_q, busy_d;

  logic                        slot_hit;
  logic                        last_slot;
  logic [NUM_SLOTS-1:0]        mask_final;

  aabb_overlap #(
    .A_W (BULLET_W),
    .A_H (BULLET_H),
    .B_W (PLAYER_W),
    .B_H (PLAYER_H)
  ) u_overlap (
    .a_valid (valid_snap_q[slot_q]),
    .a_pos   (pos_snap_q[slot_q]),
    .b_pos   (player_snap_q),
    .hit     (slot_hit)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    valid_snap_d  = valid_snap_q;
    pos_snap_d    = pos_snap_q;
    player_snap_d = player_snap_q;
    hit_mask_d    = hit_mask_q;
    invuln_d      = invuln_q;
    lives_d       = lives_q;
    bullet_kill_d = '0;
    player_hit_d  = 1'b0;

    last_slot          = (slot_q == IDX_W'(NUM_SLOTS - 1));
    mask_final         = hit_mask_q;
    mask_final[slot_q] = slot_hit;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_Tick) begin
          valid_snap_d  = bus.i_BulletValid;
          pos_snap_d    = bus.i_BulletPos;
          player_snap_d = bus.i_PlayerPos;
          hit_mask_d    = '0;
          slot_d        = '0;
          state_d       = ST_SCAN;
          if (invuln_q != '0) invuln_d = invuln_q - INV_W'(1);
        end
      end

      // Pulses are decided on the final scan edge so they are registered
      // and visible for exactly the single REPORT cycle.
      ST_SCAN: begin
        hit_mask_d = mask_final;
        if (last_slot) begin
          state_d       = ST_REPORT;
          bullet_kill_d = mask_final;
          if ((mask_final != '0) && (invuln_q == '0)) begin
            player_hit_d = 1'b1;
            lives_d      = lives_q - 2'd1;
            invuln_d     = INV_W'(INVULN_TICKS);
          end
        end else begin
          slot_d = slot_q + IDX_W'(1);
        end
      end

      ST_REPORT: begin
        state_d = (lives_q == 2'd0) ? ST_OVER : ST_IDLE;
      end

      ST_OVER: begin
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d == ST_SCAN) || (state_d == ST_REPORT);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      valid_snap_q  <= '0;
      pos_snap_q    <= '0;
      player_snap_q <= '0;
      hit_mask_q    <= '0;
      invuln_q      <= '0;
      lives_q       <= 2'(START_LIVES);
      bullet_kill_q <= '0;
      player_hit_q  <= 1'b0;
      game_over_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      valid_snap_q  <= valid_snap_d;
      pos_snap_q    <= pos_snap_d;
      player_snap_q <= player_snap_d;
      hit_mask_q    <= hit_mask_d;
      invuln_q      <= invuln_d;
      lives_q       <= lives_d;
      bullet_kill_q <= bullet_kill_d;
      player_hit_q  <= player_hit_d;
      game_over_q   <= game_over_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.o_BulletKill = bullet_kill_q;
  assign bus.o_PlayerHit  = player_hit_q;
  assign bus.o_Lives      = lives_q;
  assign bus.o_GameOver   = game_over_q;
  assign bus.o_Busy       = busy_q;

endmodule

// File: tb/tb_enemy_bullet_collide.sv
// Directed frames with hand-computed results; a monitor pops the expected
// frame report whenever o_Busy falls and checks pulses, lives and latency.
module tb_enemy_bullet_collide;
  import enemy_bullet_collide_pkg::*;

  localparam int unsigned NS = 8;
  localparam logic [18:0] P1 = {10'd302, 9'd372};
  localparam logic [18:0] P2 = {10'd1000, 9'd490};
  localparam logic [18:0] PFAR = {10'd0, 9'd0};

  typedef struct {
    logic [7:0]  kill;
    logic        hit;
    logic [1:0]  lives;
    logic        go;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  exp_t        exp_q[$];

  enemy_bullet_collide_if #(.NUM_SLOTS(NS)) bus ();

  enemy_bullet_collide #(
    .NUM_SLOTS(NS), .BULLET_W(6), .BULLET_H(20), .PLAYER_W(36), .PLAYER_H(36),
    .START_LIVES(3), .INVULN_TICKS(60)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  initial begin : monitor
    logic        pb, ph;
    logic [7:0]  pk;
    logic [1:0]  pl;
    int unsigned pc;
    exp_t        e;
    pb = 1'b0; ph = 1'b0; pk = '0; pl = '0; pc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pb = 1'b0; ph = 1'b0; pk = '0;
      end else begin
        if (pb && !bus.o_Busy) begin
          check("sb_has_entry", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("kill", pk, e.kill);
            check("player_hit", ph, e.hit);
            check("lives", pl, e.lives);
            check("latency", pc, e.cyc);
            check("game_over", bus.o_GameOver, e.go);
          end
        end else begin
          check("stray_pulse", {pk, ph}, 0);
        end
        pb = bus.o_Busy; pk = bus.o_BulletKill; ph = bus.o_PlayerHit;
        pl = bus.o_Lives; pc = cyc;
      end
    end
  end

  task automatic set_slot(input int unsigned k, input logic [9:0] x, input logic [8:0] y);
    bus.i_BulletPos[19*k +: 19] = make_pos(x, y);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!bus.o_Busy) break;
      @(negedge clk);
    end
    check("frame_idle", bus.o_Busy, 0);
  endtask

  task automatic frame(input logic [18:0] player, input logic [7:0] valid,
                       input logic [7:0] ekill, input logic ehit,
                       input logic [1:0] elives, input logic ego, input bit runs);
    exp_t e;
    @(negedge clk);
    bus.i_PlayerPos   = player;
    bus.i_BulletValid = valid;
    bus.i_Tick        = 1'b1;
    if (runs) begin
      e.kill = ekill; e.hit = ehit; e.lives = elives; e.go = ego;
      e.cyc  = cyc + NS + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.i_Tick = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bus.i_Tick = 1'b0; bus.i_BulletValid = '0; bus.i_BulletPos = '0; bus.i_PlayerPos = '0;
    repeat (3) @(negedge clk);
    check("rst_lives", bus.o_Lives, 3);
    check("rst_kill", bus.o_BulletKill, 0);
    check("rst_hit", bus.o_PlayerHit, 0);
    check("rst_go", bus.o_GameOver, 0);
    check("rst_busy", bus.o_Busy, 0);
    rst = 1'b1;

    // Single overlapping bullet in slot 0
    set_slot(0, 310, 360);
    frame(P1, 8'h01, 8'h01, 1'b1, 2'd2, 1'b0, 1);

    // Edge contact on every side: no hit
    do_reset();
    bus.i_BulletPos = '0;
    set_slot(0, 338, 372); set_slot(1, 296, 372); set_slot(2, 310, 408);
    set_slot(3, 310, 352); set_slot(5, 400, 372);
    frame(P1, 8'h2F, 8'h00, 1'b0, 2'd3, 1'b0, 1);
    // One pixel inside on right/bottom (slot 7) and left/top (slot 4)
    set_slot(7, 337, 389); set_slot(4, 297, 353);
    frame(P1, 8'hBF, 8'h90, 1'b1, 2'd2, 1'b0, 1);

    // Multiple hits, invalid overlap, parked bullet near screen corner
    do_reset();
    bus.i_BulletPos = '0;
    set_slot(1, 1010, 500); set_slot(6, 995, 480); set_slot(2, 1005, 495);
    set_slot(4, 10'h3FF, 9'h1FF);
    frame(P2, 8'h52, 8'h42, 1'b1, 2'd2, 1'b0, 1);
    // Sums beyond 10/9 bits must not wrap; invulnerable so no life lost
    bus.i_BulletPos = '0;
    set_slot(0, 1020, 505);
    frame(P2, 8'h01, 8'h01, 1'b0, 2'd2, 1'b0, 1);

    // Snapshot isolation and tick ignored while scanning
    do_reset();
    bus.i_BulletPos = '0;
    set_slot(0, 310, 360);
    @(negedge clk);
    bus.i_PlayerPos = P1; bus.i_BulletValid = 8'h01; bus.i_Tick = 1'b1;
    e.kill = 8'h01; e.hit = 1'b1; e.lives = 2'd2; e.go = 1'b0; e.cyc = cyc + NS + 1;
    exp_q.push_back(e);
    @(negedge clk); bus.i_Tick = 1'b0;
    repeat (2) @(negedge clk);
    bus.i_BulletPos = '0; set_slot(3, 310, 360);
    bus.i_BulletValid = 8'h08; bus.i_PlayerPos = PFAR; bus.i_Tick = 1'b1;
    @(negedge clk); bus.i_Tick = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("tick_ignored", bus.o_Busy, 0);

    // Invulnerability window then lives down to game over
    do_reset();
    bus.i_BulletPos = '0;
    set_slot(0, 310, 360);
    frame(P1, 8'h01, 8'h01, 1'b1, 2'd2, 1'b0, 1);
    for (int i = 1; i <= 5; i++)  frame(P1, 8'h01, 8'h01, 1'b0, 2'd2, 1'b0, 1);
    for (int i = 6; i <= 58; i++) frame(P1, 8'h00, 8'h00, 1'b0, 2'd2, 1'b0, 1);
    frame(P1, 8'h01, 8'h01, 1'b0, 2'd2, 1'b0, 1);
    frame(P1, 8'h01, 8'h01, 1'b1, 2'd1, 1'b0, 1);
    for (int i = 1; i <= 60; i++) begin
      if (i < 60) frame(P1, 8'h00, 8'h00, 1'b0, 2'd1, 1'b0, 1);
      else        frame(P1, 8'h01, 8'h01, 1'b1, 2'd0, 1'b1, 1);
    end
    for (int i = 0; i < 3; i++) frame(P1, 8'h01, 8'h00, 1'b0, 2'd0, 1'b1, 0);
    repeat (12) @(negedge clk);
    check("over_busy", bus.o_Busy, 0);
    check("over_go", bus.o_GameOver, 1);
    check("over_lives", bus.o_Lives, 0);

    // Asynchronous reset out of OVER
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_over_go", bus.o_GameOver, 0);
    check("rst_over_lives", bus.o_Lives, 3);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset mid-scan aborts; fresh tick needed afterwards
    frame(P1, 8'h01, 8'h01, 1'b1, 2'd2, 1'b0, 1);
    @(negedge clk); bus.i_Tick = 1'b1;
    @(negedge clk); bus.i_Tick = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_scan_busy", bus.o_Busy, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_lives", bus.o_Lives, 3);
    check("abort_busy", bus.o_Busy, 0);
    check("abort_kill", bus.o_BulletKill, 0);
    check("abort_hit", bus.o_PlayerHit, 0);
    check("abort_go", bus.o_GameOver, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("no_scan_after_rst", bus.o_Busy, 0);
    frame(P1, 8'h01, 8'h01, 1'b1, 2'd2, 1'b0, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enemy_bullet_collide.md
ENEMY_BULLET_COLLIDE -- requirements
Module: enemy_bullet_collide

Interface
REQ-001 Parameter NUM_SLOTS, 8, enemy bullet slots (4 enemies x 2 sets); slot index k = 2*enemy + set.
REQ-002 Parameter BULLET_W / BULLET_H, 6 / 20, bullet box size in pixels.
REQ-003 Parameter PLAYER_W / PLAYER_H, 36 / 36, player box size in pixels.
REQ-004 Parameter START_LIVES, 3, lives after reset.
REQ-005 Parameter INVULN_TICKS, 60, frames of invulnerability after a hit.
REQ-006 i_Clk  in  1  system clock, all state on rising edge.
REQ-007 i_Rst  in  1  reset, asynchronous, active-low.
REQ-008 i_Tick  in  1  one-cycle frame-start pulse.
REQ-009 i_BulletValid  in  NUM_SLOTS  per-slot live flag from the bullet generator.
REQ-010 i_BulletPos  in  19*NUM_SLOTS  slot k at bits [19k+18:19k]; each word is {x[9:0], y[8:0]}, top-left corner.
REQ-011 i_PlayerPos  in  19  player top-left, same {x,y} format.
REQ-012 o_BulletKill  out  NUM_SLOTS  one-cycle pulse per slot to retire.
REQ-013 o_PlayerHit  out  1  one-cycle pulse when a life is lost.
REQ-014 o_Lives  out  2  remaining lives.
REQ-015 o_GameOver  out  1  level, lives exhausted.
REQ-016 o_Busy  out  1  high while not in IDLE/OVER.

Function
REQ-017 FSM SHALL have states IDLE, SCAN, REPORT, OVER; all outputs SHALL be registered.
REQ-018 IDLE + i_Tick: SHALL snapshot i_BulletValid, i_BulletPos and i_PlayerPos, clear hit mask, set slot index 0, go SCAN.
REQ-019 SCAN SHALL test exactly one snapshot slot per cycle, index 0..NUM_SLOTS-1, then go REPORT.
REQ-020 A slot SHALL hit iff valid, position != DEAD_POSITION (all ones), and strict overlap: bx < px+PLAYER_W, px < bx+BULLET_W, by < py+PLAYER_H, py < by+BULLET_H.
REQ-021 Overlap sums SHALL be computed 1 bit wider than the operand (11-bit x, 10-bit y); no wrap-around.
REQ-022 Edge contact (equality) SHALL NOT count as a hit.
REQ-023 REPORT (one cycle): o_BulletKill SHALL equal the hit mask; zero mask -> no pulses.
REQ-024 REPORT with non-zero mask and invuln counter 0: o_PlayerHit pulses once, lives decrement by 1, counter loads INVULN_TICKS; multiple hits in one frame cost one life.
REQ-025 Non-zero mask while counter > 0: kill pulses still issued, no o_PlayerHit, lives unchanged.
REQ-026 After REPORT: lives 0 -> OVER, else IDLE.
REQ-027 Latency: tick accepted in cycle T -> kill/hit pulses visible in cycle T+NUM_SLOTS+1 (T+9 at default).
REQ-028 i_Tick in SCAN, REPORT or OVER SHALL be ignored (no queueing).
REQ-029 Invuln counter SHALL decrement by 1 on each accepted tick while > 0, saturating at 0.
REQ-030 OVER SHALL persist until reset; o_GameOver=1, o_Busy=0, no pulses.
REQ-031 Input changes after the snapshot SHALL NOT affect the current scan.

Reset
REQ-032 Asynchronous assert: state IDLE, o_Lives=START_LIVES, o_BulletKill=0, o_PlayerHit=0, o_GameOver=0, o_Busy=0, counter 0, mask 0, snapshot cleared.
REQ-033 Reset mid-scan SHALL abort with no pulses; first scan after release requires a fresh i_Tick.

Structure
REQ-034 Shared game package SHALL hold slot count, 19-bit {x,y} position format, DEAD_POSITION, bullet and player dimensions, START_LIVES.
REQ-035 One combinational sub-module, aabb_overlap (two boxes in, one hit bit out), SHALL implement REQ-020..REQ-022 and be reused by the player-bullet collider.

Verification
REQ-036 Player {302,372}, slot 0 valid {310,360}, tick -> cycle T+9: o_BulletKill=8'h01, o_PlayerHit=1, o_Lives=2.
REQ-037 Slot 3 valid {310,352} (bottom edge y=372 touches) and slot 5 {400,372} -> o_BulletKill=0, no hit, lives 3.
REQ-038 Slots 1 and 6 overlapping, slot 2 overlapping but valid=0, slot 4 at DEAD_POSITION valid=1 -> o_BulletKill=8'h42, lives -1 exactly once.
REQ-039 Hit, then overlap on the next 5 ticks with INVULN_TICKS=60 -> kills each frame, no further o_PlayerHit; after 60 ticks next overlap costs a life.
REQ-040 Three hit frames spaced > INVULN_TICKS -> o_Lives 3,2,1,0, o_GameOver=1, later ticks and overlaps produce no pulses; i_Rst low mid-scan -> all outputs to reset values immediately.
